// File: rtl/quote_egress_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : quote_egress_scheduler
// Description : Queues buy/sell quote pairs and streams each pair word by word,
//               buy message first, then sell, with an idle gap after each pair.
// Revision    : 1.0 - initial release
// ============================================================================
module quote_egress_scheduler #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 9,
  parameter int DEPTH     = 4,
  parameter int MIN_GAP   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_quote_valid,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_buy_words,
  input  logic [NUM_REGS*REG_WIDTH-1:0] i_sell_words,
  input  logic                          i_hold,
  input  logic                          i_halt,
  input  logic                          i_word_ready,
  output logic [REG_WIDTH-1:0]          o_word,
  output logic                          o_word_valid,
  output logic                          o_side,
  output logic                          o_last,
  output logic [$clog2(DEPTH):0]        o_fifo_level,
  output logic [15:0]                   o_drop_count,
  output logic                          o_busy
);

  localparam int c_MSG_W = NUM_REGS * REG_WIDTH;
  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int c_GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_REGS - 1);
  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(MIN_GAP);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_BUY  = 2'd1,
    ST_SEND_SELL = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [c_IDX_W-1:0]   idx_q, idx_d;
  logic [c_GAP_W-1:0]   gap_q, gap_d;
  logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [c_LVL_W-1:0]   level_q, level_d;
  logic [15:0]          drop_q, drop_d;

  logic [c_MSG_W-1:0]   buy_mem_q  [DEPTH];
  logic [c_MSG_W-1:0]   sell_mem_q [DEPTH];

  logic                 w_sending;
  logic                 w_hs;
  logic                 w_last_hs;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [c_MSG_W-1:0]   w_head_msg;
  logic [REG_WIDTH-1:0] w_word_sel;

  assign w_sending = (state_q == ST_SEND_BUY) || (state_q == ST_SEND_SELL);
  assign w_hs      = w_sending && i_word_ready;
  assign w_last_hs = w_hs && (idx_q == c_LAST_IDX);
  assign w_pop     = (state_q == ST_SEND_SELL) && w_last_hs;

  // A full FIFO still takes a pair when the head leaves in the same cycle.
  assign w_push = i_quote_valid && !i_halt && ((level_q < c_FULL_LVL) || w_pop);
  assign w_drop = i_quote_valid && !i_halt && !w_push;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if ((level_q != '0) && !i_hold) begin
          state_d = ST_SEND_BUY;
          idx_d   = '0;
        end
      end
      ST_SEND_BUY: begin
        if (w_hs) begin
          if (idx_q == c_LAST_IDX) begin
            state_d = ST_SEND_SELL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + c_IDX_W'(1);
          end
        end
      end
      ST_SEND_SELL: begin
        if (w_hs) begin
          if (idx_q == c_LAST_IDX) begin
            idx_d = '0;
            if (MIN_GAP == 0) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_GAP;
              gap_d   = c_GAP_LOAD;
            end
          end else begin
            idx_d = idx_q + c_IDX_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_q <= c_GAP_W'(1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - c_GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        gap_d   = '0;
      end
    endcase
    if (i_halt) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      gap_d   = '0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + c_PTR_W'(w_push);
    rd_ptr_d = rd_ptr_q + c_PTR_W'(w_pop);
    level_d  = level_q;
    drop_d   = drop_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + c_LVL_W'(1);
      2'b01:   level_d = level_q - c_LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (w_drop && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
    // Halt flushes the queue but keeps the drop statistic.
    if (i_halt) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage needs no reset; it is only observed through valid entries.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_push) begin
      buy_mem_q[wr_ptr_q]  <= i_buy_words;
      sell_mem_q[wr_ptr_q] <= i_sell_words;
    end
  end

  assign w_head_msg = (state_q == ST_SEND_SELL) ? sell_mem_q[rd_ptr_q] : buy_mem_q[rd_ptr_q];

  always_comb begin
    w_word_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx_q == c_IDX_W'(k)) begin
        w_word_sel = w_head_msg[k*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  assign o_word_valid = w_sending;
  assign o_word       = w_sending ? w_word_sel : '0;
  assign o_side       = (state_q == ST_SEND_SELL);
  assign o_last       = w_sending && (idx_q == c_LAST_IDX);
  assign o_fifo_level = level_q;
  assign o_drop_count = drop_q;
  assign o_busy       = (state_q != ST_IDLE) || (level_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_quote_egress_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_quote_egress_scheduler
// Description : Directed scoreboard bench for quote_egress_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quote_egress_scheduler;

  localparam int c_W     = 32;
  localparam int c_N     = 9;
  localparam int c_MSG_W = c_W * c_N;

  logic               clk;
  logic               reset;
  logic               quote_valid;
  logic [c_MSG_W-1:0] buy_words;
  logic [c_MSG_W-1:0] sell_words;
  logic               hold;
  logic               halt;
  logic               word_ready;
  logic [c_W-1:0]     word;
  logic               word_valid;
  logic               side;
  logic               last;
  logic [2:0]         fifo_level;
  logic [15:0]        drop_count;
  logic               busy;

  int total;
  int bad;
  int hs_count;
  int exp_drop;
  logic [33:0] exp_q[$];

  quote_egress_scheduler #(
    .REG_WIDTH(c_W),
    .NUM_REGS (c_N),
    .DEPTH    (4),
    .MIN_GAP  (2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_quote_valid(quote_valid),
    .i_buy_words  (buy_words),
    .i_sell_words (sell_words),
    .i_hold       (hold),
    .i_halt       (halt),
    .i_word_ready (word_ready),
    .o_word       (word),
    .o_word_valid (word_valid),
    .o_side       (side),
    .o_last       (last),
    .o_fifo_level (fifo_level),
    .o_drop_count (drop_count),
    .o_busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [c_MSG_W-1:0] mk(input logic [31:0] base);
    logic [c_MSG_W-1:0] m;
    m = '0;
    for (int k = 0; k < c_N; k++) m[k*c_W +: c_W] = base + 32'(k);
    return m;
  endfunction

  // Queue the words expected on the wire: nb buy words then ns sell words.
  task automatic push_exp(input logic [31:0] bb, input logic [31:0] sb, input int nb, input int ns);
    for (int k = 0; k < nb; k++) exp_q.push_back({1'b0, (k == c_N - 1), bb + 32'(k)});
    for (int k = 0; k < ns; k++) exp_q.push_back({1'b1, (k == c_N - 1), sb + 32'(k)});
  endtask

  task automatic drive_quote(input logic [31:0] bb, input logic [31:0] sb);
    quote_valid = 1'b1;
    buy_words   = mk(bb);
    sell_words  = mk(sb);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      tick();
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_not_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic monitor();
    logic [33:0] act_e;
    logic [33:0] prev_e;
    logic [33:0] exp_e;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_e     = '0;
    forever begin
      @(negedge clk);
      act_e = {side, last, word};
      if (prev_stall && word_valid) check("held_word_stable", 64'(act_e), 64'(prev_e));
      if (word_valid && word_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got side=%0d last=%0d word=0x%0h, none expected", side, last, word);
        end else begin
          exp_e = exp_q.pop_front();
          check("out_word", 64'(act_e), 64'(exp_e));
        end
      end
      prev_stall = word_valid && !word_ready;
      prev_e     = act_e;
    end
  endtask

  initial begin
    int hs_start;
    total       = 0;
    bad         = 0;
    hs_count    = 0;
    exp_drop    = 0;
    reset       = 1'b1;
    quote_valid = 1'b0;
    buy_words   = '0;
    sell_words  = '0;
    hold        = 1'b0;
    halt        = 1'b0;
    word_ready  = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    tick();
    tick();
    check("rst_valid", {63'd0, word_valid}, 64'd0);
    check("rst_word", 64'(word), 64'd0);
    check("rst_last", {63'd0, last}, 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();

    // Single pair: latency, ordering, gap
    drive_quote(32'h100, 32'h200);
    push_exp(32'h100, 32'h200, 9, 9);
    tick();
    quote_valid = 1'b0;
    check("lat_level_c1", 64'(fifo_level), 64'd1);
    check("lat_valid_c1", {63'd0, word_valid}, 64'd0);
    tick();
    check("lat_valid_c2", {63'd0, word_valid}, 64'd1);
    check("lat_word_c2", 64'(word), 64'h100);
    repeat (18) tick();
    check("gap_valid_c20", {63'd0, word_valid}, 64'd0);
    check("gap_busy_c20", {63'd0, busy}, 64'd1);
    check("gap_level_c20", 64'(fifo_level), 64'd0);
    tick();
    check("gap_valid_c21", {63'd0, word_valid}, 64'd0);
    tick();
    check("idle_busy_c22", {63'd0, busy}, 64'd0);
    check("single_all_out", 64'(exp_q.size()), 64'd0);

    // Backpressure on alternate cycles
    hs_start = hs_count;
    push_exp(32'h300, 32'h400, 9, 9);
    for (int c = 0; c < 80; c++) begin
      word_ready = c[0];
      if (c == 0) drive_quote(32'h300, 32'h400);
      else quote_valid = 1'b0;
      tick();
    end
    word_ready = 1'b1;
    drain();
    check("bp_handshakes", 64'(hs_count - hs_start), 64'd18);

    // Overflow while held
    hold = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_quote(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
      if (i < 4) push_exp(32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 9, 9);
      tick();
    end
    quote_valid = 1'b0;
    exp_drop = 2;
    check("ovf_level", 64'(fifo_level), 64'd4);
    check("ovf_drop", 64'(drop_count), 64'(exp_drop));
    tick();
    check("ovf_hold_no_start", {63'd0, word_valid}, 64'd0);
    hold = 1'b0;
    drain();
    check("ovf_drop_after", 64'(drop_count), 64'(exp_drop));

    // Full FIFO with push on the final sell handshake
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_quote(32'h3000 + 32'(i * 16), 32'h4000 + 32'(i * 16));
      push_exp(32'h3000 + 32'(i * 16), 32'h4000 + 32'(i * 16), 9, 9);
      tick();
    end
    quote_valid = 1'b0;
    check("full_level", 64'(fifo_level), 64'd4);
    hold = 1'b0;
    repeat (18) tick();
    check("full_last_sell", 64'({side, last, word}), 64'({1'b1, 1'b1, 32'h4008}));
    drive_quote(32'h3040, 32'h4040);
    push_exp(32'h3040, 32'h4040, 9, 9);
    tick();
    quote_valid = 1'b0;
    check("full_pop_push_level", 64'(fifo_level), 64'd4);
    check("full_pop_push_drop", 64'(drop_count), 64'(exp_drop));
    drain();

    // Halt mid buy message, with a push in the halt cycle
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_quote(32'h5000 + 32'(i * 16), 32'h6000 + 32'(i * 16));
      tick();
    end
    quote_valid = 1'b0;
    check("halt_pre_level", 64'(fifo_level), 64'd3);
    push_exp(32'h5000, 32'h6000, 4, 0);
    hold = 1'b0;
    repeat (5) tick();
    check("halt_at_idx4", 64'(word), 64'h5004);
    halt       = 1'b1;
    word_ready = 1'b0;
    drive_quote(32'h5100, 32'h6100);
    tick();
    halt        = 1'b0;
    quote_valid = 1'b0;
    word_ready  = 1'b1;
    check("halt_valid", {63'd0, word_valid}, 64'd0);
    check("halt_level", 64'(fifo_level), 64'd0);
    check("halt_busy", {63'd0, busy}, 64'd0);
    check("halt_drop", 64'(drop_count), 64'(exp_drop));
    repeat (3) tick();
    check("halt_stays_idle", {63'd0, word_valid}, 64'd0);
    check("halt_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset during sell message, then fresh quote latency
    drive_quote(32'h700, 32'h800);
    push_exp(32'h700, 32'h800, 9, 3);
    tick();
    quote_valid = 1'b0;
    repeat (13) tick();
    check("rst_mid_sell_idx3", 64'({side, word}), 64'({1'b1, 32'h803}));
    reset      = 1'b1;
    word_ready = 1'b0;
    tick();
    reset      = 1'b0;
    word_ready = 1'b1;
    exp_drop   = 0;
    check("rst2_valid", {63'd0, word_valid}, 64'd0);
    check("rst2_word", 64'({side, last, word}), 64'd0);
    check("rst2_level", 64'(fifo_level), 64'd0);
    check("rst2_drop", 64'(drop_count), 64'(exp_drop));
    check("rst2_busy", {63'd0, busy}, 64'd0);
    check("rst2_queue_empty", 64'(exp_q.size()), 64'd0);
    drive_quote(32'h900, 32'hA00);
    push_exp(32'h900, 32'hA00, 9, 9);
    tick();
    quote_valid = 1'b0;
    check("rst2_lat_level", 64'(fifo_level), 64'd1);
    check("rst2_lat_valid_c1", {63'd0, word_valid}, 64'd0);
    tick();
    check("rst2_lat_valid_c2", {63'd0, word_valid}, 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/quote_egress_scheduler.md
QUOTE_EGRESS_SCHEDULER -- requirements
Module: quote_egress_scheduler

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  REG_WIDTH, 32, bits per message word
  NUM_REGS, 9, words per order message
  DEPTH, 4, quote-pair FIFO entries (power of 2, >=2)
  MIN_GAP, 2, idle cycles enforced after each buy+sell pair (0 allowed)
REQ-002 Ports SHALL be (name, direction, width, meaning):
  i_clk  in  1  single clock, all logic on rising edge
  i_reset  in  1  synchronous, active-high reset
  i_quote_valid  in  1  one-cycle strobe: buy and sell messages present
  i_buy_words  in  NUM_REGS*REG_WIDTH  buy message, word k at bits [k*REG_WIDTH +: REG_WIDTH]
  i_sell_words  in  NUM_REGS*REG_WIDTH  sell message, same packing
  i_hold  in  1  downstream pause; blocks start of a new pair only
  i_halt  in  1  kill switch: abort and flush
  i_word_ready  in  1  downstream accepts current word
  o_word  out  REG_WIDTH  current outgoing word
  o_word_valid  out  1  o_word valid
  o_side  out  1  0 = buy message, 1 = sell message
  o_last  out  1  current word is word NUM_REGS-1
  o_fifo_level  out  $clog2(DEPTH)+1  stored pairs
  o_drop_count  out  16  quotes dropped on full FIFO, saturating
  o_busy  out  1  FSM not IDLE or FIFO not empty

Function
REQ-003 Each i_quote_valid cycle SHALL push one {buy,sell} pair unless rejected.
REQ-004 Push SHALL be accepted if level < DEPTH, or level == DEPTH with a pop in the same cycle; otherwise the pair is discarded and o_drop_count increments (saturates at 16'hFFFF).
REQ-005 Pop SHALL occur on the handshake (o_word_valid & i_word_ready) of the sell message's last word; simultaneous push and pop SHALL leave level unchanged.
REQ-006 FSM states SHALL be IDLE, SEND_BUY, SEND_SELL, GAP, with word index idx in 0..NUM_REGS-1.
REQ-007 IDLE -> SEND_BUY (idx=0) when level>0, i_hold=0, i_halt=0; otherwise stay IDLE.
REQ-008 SEND_BUY: o_word = head buy word idx, o_side=0; handshake increments idx; handshake at idx=NUM_REGS-1 -> SEND_SELL, idx=0.
REQ-009 SEND_SELL: o_word = head sell word idx, o_side=1; handshake at idx=NUM_REGS-1 pops and -> GAP loaded with MIN_GAP, or -> IDLE if MIN_GAP=0.
REQ-010 GAP: counter decrements each cycle; -> IDLE in the cycle it reads 1; o_word_valid=0.
REQ-011 o_word_valid SHALL be 1 exactly in SEND_BUY/SEND_SELL; o_word, o_side, o_last SHALL hold stable while o_word_valid=1 and i_word_ready=0.
REQ-012 o_last SHALL equal o_word_valid & (idx==NUM_REGS-1).
REQ-013 i_hold SHALL NOT interrupt a pair in progress; a pair, once started, always completes both messages absent i_halt/i_reset.
REQ-014 Latency: i_quote_valid in cycle 0, FIFO empty, IDLE, no hold -> o_fifo_level=1 in cycle 1, first buy word valid in cycle 2.
REQ-015 i_halt=1 SHALL, at the next edge, force IDLE, idx=0, level=0; a push in the same cycle is discarded and not counted; o_drop_count is retained.
REQ-016 The buy message SHALL always precede its sell message; pairs SHALL leave in arrival order.

Reset
REQ-017 i_reset=1 at an edge SHALL force IDLE, idx=0, GAP counter 0, FIFO empty, o_drop_count=0; outputs o_word_valid=0, o_word=0, o_side=0, o_last=0, o_fifo_level=0, o_busy=0.
REQ-018 Reset SHALL take priority over i_halt, push and pop, including mid-message.

Verification
REQ-019 Single pair, i_word_ready=1: buy words 0x100..0x108, sell 0x200..0x208 in cycle 0 -> valid cycles 2-19 emit 0x100..0x108 (o_side=0) then 0x200..0x208 (o_side=1), o_last at 0x108 and 0x208, then 2 idle cycles, o_busy=0.
REQ-020 Backpressure: i_word_ready low on alternate cycles -> each word held stable until accepted; 18 handshakes; no word skipped or duplicated.
REQ-021 Overflow: 6 strobes on consecutive cycles, i_hold=1 -> o_fifo_level=4, o_drop_count=2; release hold -> 4 pairs out in push order.
REQ-022 Full + pop same cycle: level=4, push on final sell-word handshake -> push accepted, level stays 4, drop count unchanged.
REQ-023 Halt mid-message: i_halt at buy idx=4 with level=3 -> next cycle o_word_valid=0, level=0, IDLE; o_drop_count unchanged.
REQ-024 Reset during SEND_SELL -> all outputs at reset values next cycle; fresh quote afterwards follows REQ-014 latency.
